// File: rtl/iomem_arb_pkg.sv
// Shared types and constants for the two-master iomem arbiter.
package iomem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/iomem_rr_pick.sv
// Two-request round-robin picker: the master not granted last time wins a tie.
module iomem_rr_pick
  import iomem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_M0;
      2'b10:   grant = GNT_M1;
      2'b11:   grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the iomem valid/ready bus, one transaction in flight.
// Optional slave timeout enabled by defining IOMEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; sample master requests and latch the winner's fields
// REQ   | s_valid_o high with latched fields, waiting for s_ready_i
// RESP  | one-cycle ready pulse to the owner, grant released
module iomem_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  m0_valid_i,
  output logic                  m0_ready_o,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_wstrb_i,
  output logic [DATA_W-1:0]     m0_rdata_o,
  input  logic                  m1_valid_i,
  output logic                  m1_ready_o,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  s_valid_o,
  input  logic                  s_ready_i,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic [DATA_W-1:0]     s_rdata_i,
  output logic [1:0]            grant_o,
  output logic                  err_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state;
  logic [1:0]          last_grant;
  logic [1:0]          req;
  logic [1:0]          pick;
  logic                resp_fire;
  logic [DATA_W-1:0]   resp_data;

  assign req = {m1_valid_i, m0_valid_i};

  iomem_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             resp_err;

  // A slave ready in the timeout cycle takes priority over the abort.
  always_comb begin
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    resp_data = s_rdata_i;
    if (state == REQ) begin
      if (s_ready_i) begin
        resp_fire = 1'b1;
      end else if (tmo_cnt == TMO_LAST) begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
        resp_data = DATA_W'(ERR_RDATA);
      end
    end
  end
`else
  always_comb begin
    resp_fire = (state == REQ) && s_ready_i;
    resp_data = s_rdata_i;
  end

  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_M1;
      grant_o    <= GNT_NONE;
      s_valid_o  <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      s_wstrb_o  <= '0;
      m0_ready_o <= 1'b0;
      m1_ready_o <= 1'b0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
`ifdef IOMEM_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_o      <= 1'b0;
`endif
    end else begin
      m0_ready_o <= 1'b0;
      m1_ready_o <= 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
      err_o      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            state     <= REQ;
            grant_o   <= pick;
            s_valid_o <= 1'b1;
            s_addr_o  <= pick[1] ? m1_addr_i  : m0_addr_i;
            s_wdata_o <= pick[1] ? m1_wdata_i : m0_wdata_i;
            s_wstrb_o <= pick[1] ? m1_wstrb_i : m0_wstrb_i;
            // Only a real contention moves the round-robin pointer.
            if (req == 2'b11) last_grant <= pick;
`ifdef IOMEM_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        REQ: begin
          if (resp_fire) begin
            state      <= RESP;
            s_valid_o  <= 1'b0;
            m0_ready_o <= grant_o[0];
            m1_ready_o <= grant_o[1];
            if (grant_o[0]) m0_rdata_o <= resp_data;
            if (grant_o[1]) m1_rdata_o <= resp_data;
`ifdef IOMEM_ARB_TIMEOUT_EN
            err_o      <= resp_err;
`endif
          end
`ifdef IOMEM_ARB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state   <= IDLE;
          grant_o <= GNT_NONE;
        end
        default: begin
          state     <= IDLE;
          grant_o   <= GNT_NONE;
          s_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
